// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART command receiver and its bench.
//   - rx_state_t      : receiver FSM states
//   - BAUD_DIV_19200  : clocks per bit at 50 MHz / 19200 baud
//   - G, S            : command bytes carried on the BLE link
//   - half_div()      : clocks from a start edge to the middle of the start bit
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2
  } rx_state_t;

  localparam int BAUD_DIV_19200 = 2604;

  localparam logic [7:0] G = 8'h47;
  localparam logic [7:0] S = 8'h53;

  function automatic int half_div(input int baud_div);
    return baud_div / 2;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt
//   Loadable down-counter that paces the receiver's bit sampling.
//   Ports:
//     clk        in  1      system clock
//     rst        in  1      synchronous active-high reset
//     load_i     in  1      load a new interval this clock
//     load_val_i in  WIDTH  interval length in clocks
//     zero_o     out 1      interval has elapsed; act on the next edge
module uart_baud_cnt #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  // The load clock itself counts as one tick, so loading val-1 makes the
  // next action edge land exactly load_val_i clocks after the load edge.
  // The counter parks at zero until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i - WIDTH'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
//   8N1 UART receiver feeding the Segway command path. RX is synchronized,
//   a falling edge starts a frame, each bit is sampled mid-period and the
//   byte is offered on rx_data with a rdy / clr_rdy handshake.
//   Ports:
//     clk      in  1  system clock
//     rst      in  1  synchronous active-high reset
//     RX       in  1  asynchronous serial input, idles high
//     clr_rdy  in  1  consumer acknowledge, clears rdy
//     rx_data  out 8  last received byte (LSB first on the wire)
//     rdy      out 1  a byte is waiting in rx_data
//     frm_err  out 1  one-clock pulse on a bad stop bit
//   Build option: define UART_RX_FRAME_ERR_EN to discard frames whose stop
//   bit samples 0 and pulse frm_err; otherwise the stop bit is ignored and
//   frm_err is tied low.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int HALF_DIV = half_div(BAUD_DIV);
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV);

  rx_state_t        state_q, state_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rdy_q, rdy_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
`ifdef UART_RX_FRAME_ERR_EN
  logic             frm_err_q, frm_err_d;
`endif

  uart_baud_cnt #(.WIDTH(CNT_W)) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .zero_o    (cnt_zero)
  );

  // Two-flop synchronizer plus one history flop for edge detection. All
  // preset high so reset release never looks like a start edge, and a line
  // held low (break) cannot retrigger until it has gone high again.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= frm_err_d;
    end
  end
`endif

  // Next-state logic. The stop bit is judged straight from rx_s on its own
  // sample, so the shift register only ever needs to hold the 8 data bits.
  // A completing frame writes rdy after the clr_rdy default, so set wins.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rdy_d        = rdy_q & ~clr_rdy;
    cnt_load     = 1'b0;
    cnt_load_val = BAUD_LOAD;
`ifdef UART_RX_FRAME_ERR_EN
    frm_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          cnt_load     = 1'b1;
          cnt_load_val = HALF_LOAD;
          rdy_d        = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            cnt_load  = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = RECV;
          end
        end
      end
      RECV: begin
        if (cnt_zero) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
            if (rx_s_q) begin
              rx_data_d = shift_q;
              rdy_d     = 1'b1;
            end else begin
              frm_err_d = 1'b1;
            end
`else
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
`endif
          end else begin
            shift_d  = {rx_s_q, shift_q[7:1]};
            cnt_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign frm_err = frm_err_q;
`else
  assign frm_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx
//   Self-checking bench for uart_cmd_rx, run at a short bit period so that
//   every frame scenario fits in a brief simulation. Expected bytes go into
//   a scoreboard queue when a frame is driven and are popped when rdy rises.
//   Honours UART_RX_FRAME_ERR_EN to pick the bad-stop-bit expectations.
module tb_uart_cmd_rx;
  import uart_pkg::*;

  localparam int B       = 32;
  localparam int HALF    = B / 2;
  localparam int LAT_NOM = (B * 19) / 2 + 2;
  localparam int LAT_TOL = 4;
`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FRAME_ERR_EN = 1'b1;
`else
  localparam bit FRAME_ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic       clrAfter;
    logic       pushes;
    logic       expRdy;
    logic [7:0] expData;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int         compared = 0;
  int         mismatched = 0;
  int         cycleCnt = 0;
  int         startCycle = 0;
  int         frmErrCount = 0;
  int         monLat;
  logic [7:0] monExp;
  logic [7:0] expQ[$];
  logic       rdyPrev = 1'b0;
  logic       frmErrPrev = 1'b0;
  bit         monitorOn = 1'b0;
  vec_t       vecs[5];

  uart_cmd_rx #(.BAUD_DIV(B)) dut (
    .clk    (clk),
    .rst    (rst),
    .RX     (RX),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, required);
    end
  endtask

  // Scoreboard monitor: every rising rdy must match the oldest queued byte
  // and arrive inside the latency window; frm_err must be single-clock.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (rdy === 1'b1 && rdyPrev !== 1'b1) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedRdy: got rdy=1 rx_data=0x%0h, wanted no byte pending", rx_data);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("sbRxData", {24'd0, rx_data}, {24'd0, monExp});
          monLat = cycleCnt - startCycle;
          compared++;
          if (monLat < LAT_NOM - LAT_TOL || monLat > LAT_NOM + LAT_TOL) begin
            mismatched++;
            $display("[TB] FAIL rdyLatency: got %0d clks, wanted %0d +/- %0d", monLat, LAT_NOM, LAT_TOL);
          end
        end
      end
      if (frm_err === 1'b1) begin
        if (frmErrPrev === 1'b1) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL frmErrWidth: got frm_err high 2+ clks, wanted 1");
        end else begin
          frmErrCount++;
        end
      end
      rdyPrev    = rdy;
      frmErrPrev = frm_err;
    end
  end

  // Drives a start bit then the first nBits of {stop, data}, LSB first.
  // Must be called at a falling clock edge.
  task automatic driveFrame(input logic [7:0] data, input logic stopBit,
                            input int nBits, input bit checkDrop);
    logic [8:0] bits;
    logic       rdyBefore;
    bits      = {stopBit, data};
    rdyBefore = rdy;
    startCycle = cycleCnt;
    RX = 1'b0;
    repeat (2) @(negedge clk);
    if (checkDrop && rdyBefore === 1'b1) checkOutput("rdyHoldPreStart", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    if (checkDrop && rdyBefore === 1'b1) checkOutput("rdyDropOnStart", {31'd0, rdy}, 32'd0);
    repeat (B - 3) @(negedge clk);
    for (int i = 0; i < nBits; i++) begin
      RX = bits[i];
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.pushes) expQ.push_back(v.data);
    driveFrame(v.data, v.stopBit, 9, 1'b1);
    if (!v.stopBit) begin
      RX = 1'b1;
      repeat (2 * B) @(negedge clk);
    end
    if (v.clrAfter) begin
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got simulation still running, wanted finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{data: G,     stopBit: 1'b1, clrAfter: 1'b1, pushes: 1'b1,
                expRdy: 1'b0, expData: G};
    vecs[1] = '{data: S,     stopBit: 1'b1, clrAfter: 1'b0, pushes: 1'b1,
                expRdy: 1'b1, expData: S};
    vecs[2] = '{data: 8'hA5, stopBit: 1'b1, clrAfter: 1'b0, pushes: 1'b1,
                expRdy: 1'b1, expData: 8'hA5};
    vecs[3] = '{data: 8'h3C, stopBit: 1'b0, clrAfter: 1'b0, pushes: !FRAME_ERR_EN,
                expRdy: !FRAME_ERR_EN, expData: FRAME_ERR_EN ? 8'hA5 : 8'h3C};
    vecs[4] = '{data: 8'h5A, stopBit: 1'b1, clrAfter: 1'b1, pushes: 1'b1,
                expRdy: 1'b0, expData: 8'h5A};

    // Reset and idle line.
    rst = 1'b1;
    RX  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    monitorOn = 1'b1;
    checkOutput("resetRdy", {31'd0, rdy}, 32'd0);
    checkOutput("resetRxData", {24'd0, rx_data}, 32'h00);
    checkOutput("resetFrmErr", {31'd0, frm_err}, 32'd0);
    repeat (10000) @(negedge clk);
    checkOutput("idleRdy", {31'd0, rdy}, 32'd0);
    checkOutput("idleRxData", {24'd0, rx_data}, 32'h00);

    // Table of frames, sent back-to-back.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0dRdy", i), {31'd0, rdy}, {31'd0, vecs[i].expRdy});
      checkOutput($sformatf("vec%0dRxData", i), {24'd0, rx_data}, {24'd0, vecs[i].expData});
    end
    checkOutput("frmErrPulses", frmErrCount, FRAME_ERR_EN ? 32'd1 : 32'd0);

    // Glitch shorter than half a bit must be rejected.
    RX = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    checkOutput("glitchRdy", {31'd0, rdy}, 32'd0);
    checkOutput("glitchRxData", {24'd0, rx_data}, 32'h5A);
    expQ.push_back(S);
    driveFrame(S, 1'b1, 9, 1'b1);
    checkOutput("postGlitchRdy", {31'd0, rdy}, 32'd1);
    checkOutput("postGlitchRxData", {24'd0, rx_data}, {24'd0, S});

    // Reset in the middle of a frame, after data bit 4.
    driveFrame(8'hFF, 1'b1, 5, 1'b1);
    RX  = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("midResetRdy", {31'd0, rdy}, 32'd0);
    checkOutput("midResetRxData", {24'd0, rx_data}, 32'h00);
    checkOutput("midResetFrmErr", {31'd0, frm_err}, 32'd0);
    repeat (B) @(negedge clk);

    // Next frame completes on the same clock that clr_rdy is asserted.
    expQ.push_back(8'h12);
    fork
      driveFrame(8'h12, 1'b1, 9, 1'b0);
      begin
        repeat (LAT_NOM) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    checkOutput("setWinsRdy", {31'd0, rdy}, 32'd1);
    checkOutput("setWinsRxData", {24'd0, rx_data}, 32'h12);

    repeat (B) @(negedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
